sum_tx: RTL and testbench

- Transmit side of the inter-core softmax-sum exchange.
- Takes this core's signed psum vectors, reduces each vector to one absolute-value row sum, and buffers the sums in a FIFO.
- Delivers the sums in order to the peer core's normalizer over a 4-phase req/ack handshake.
- The peer uses each delivered value as its external partial sum (sum_in) when it builds the 2-core denominator.

---
 rtl/sum_tx.sv | 136 +++++++++++++
 tb/tb_sum_tx.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_tx.sv
// Transmit side of the inter-core softmax-sum exchange: reduces psum vectors to
// absolute row sums, queues them, and hands them to the peer over 4-phase req/ack.
//
// state   | meaning
// IDLE    | no sum on the link; launch when a sum is queued and ack is low
// REQ     | sum_out valid, sum_req high, waiting for peer ack
// RELEASE | sum popped, waiting for peer to drop ack
module sum_tx #(
    parameter int col     = 8,
    parameter int bw      = 8,
    parameter int bw_psum = 2*bw+4,
    parameter int DEPTH   = 8,
    parameter int AW      = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    acc_valid,
    input  logic [col*bw_psum-1:0]  sfp_in,
    output logic                    acc_ready,
    output logic [bw_psum+3:0]      sum_out,
    output logic                    sum_req,
    input  logic                    sum_ack,
    output logic                    fifo_full,
    output logic                    fifo_empty,
    output logic [AW:0]             fifo_count
);
    localparam int SW = bw_psum + 4;
    localparam logic [bw_psum-1:0] ONE = {{(bw_psum-1){1'b0}}, 1'b1};
    localparam logic [AW+1:0] DEPTH_OCC = DEPTH[AW+1:0];
    localparam logic [AW:0]   DEPTH_CNT = DEPTH[AW:0];

    typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

    state_t              state, state_nxt;
    logic [bw_psum-1:0]  elem, mag;
    logic [SW-1:0]       row_sum;
    logic [SW-1:0]       s1_sum;
    logic                s1_valid;
    logic [SW-1:0]       mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         count;
    logic [AW+1:0]       occ;
    logic                accept, push, pop, load;

    // Two's-complement magnitude; the most-negative value maps to 2^(bw_psum-1) unsigned.
    always_comb begin
        row_sum = '0;
        elem    = '0;
        mag     = '0;
        for (int k = 0; k < col; k++) begin
            elem    = sfp_in[bw_psum*k +: bw_psum];
            mag     = elem[bw_psum-1] ? (~elem + ONE) : elem;
            row_sum = row_sum + {4'b0000, mag};
        end
    end

    // Counting s1 in the occupancy guarantees a slot for the sum already in flight.
    assign occ        = {1'b0, count} + {{(AW+1){1'b0}}, s1_valid};
    assign acc_ready  = occ < DEPTH_OCC;
    assign accept     = acc_valid && acc_ready;
    assign push       = s1_valid;
    assign fifo_count = count;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_CNT);
    assign sum_req    = (state == REQ);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept)
                s1_sum <= row_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= s1_sum;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            sum_out <= '0;
        end else begin
            state <= state_nxt;
            if (load)
                sum_out <= mem[rd_ptr];
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !sum_ack) begin
                    load      = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (sum_ack) begin
                    pop       = 1'b1;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (!sum_ack)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sum_tx.sv
// Directed self-checking bench for sum_tx: reduction values, latency, flow control,
// FIFO ordering/wrap, early-ack blocking and mid-handshake reset.
module tb_sum_tx;
    localparam int COL = 8;
    localparam int BWP = 20;
    localparam int SW  = BWP + 4;

    logic                 clk;
    logic                 reset;
    logic                 acc_valid;
    logic [COL*BWP-1:0]   sfp_in;
    logic                 acc_ready;
    logic [SW-1:0]        sum_out;
    logic                 sum_req;
    logic                 sum_ack;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [3:0]           fifo_count;

    int n_checks = 0;
    int n_errors = 0;

    sum_tx #(.col(8), .bw(8), .bw_psum(20), .DEPTH(8), .AW(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .acc_valid  (acc_valid),
        .sfp_in     (sfp_in),
        .acc_ready  (acc_ready),
        .sum_out    (sum_out),
        .sum_req    (sum_req),
        .sum_ack    (sum_ack),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [COL*BWP-1:0] vec8(input int a0, input int a1, input int a2,
                                                input int a3, input int a4, input int a5,
                                                input int a6, input int a7);
        int e[8];
        logic [COL*BWP-1:0] r;
        e = '{a0, a1, a2, a3, a4, a5, a6, a7};
        r = '0;
        for (int k = 0; k < COL; k++)
            r[k*BWP +: BWP] = BWP'(e[k]);
        return r;
    endfunction

    function automatic logic [COL*BWP-1:0] vec1(input int v);
        return vec8(v, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [COL*BWP-1:0] v);
        acc_valid = 1'b1;
        sfp_in    = v;
        tick();
        acc_valid = 1'b0;
    endtask

    // Waits (bounded) for sum_req, captures sum_out, then runs ack high/low.
    task automatic do_handshake(output logic [SW-1:0] val, output bit ok);
        ok  = 1'b0;
        val = '0;
        for (int i = 0; i < 20; i++) begin
            if (sum_req) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) begin
            val     = sum_out;
            sum_ack = 1'b1;
            tick();
            sum_ack = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; acc_valid = 1'b0; sfp_in = '0; sum_ack = 1'b0;
        #12;
        n_checks++;
        if ({sum_req, acc_ready, fifo_empty, fifo_full} !== 4'b0110 || fifo_count !== 4'd0 || sum_out !== '0) begin
            n_errors++;
            $display("FAIL reset_state: req/rdy/empty/full=%b count=%0d sum_out=%0h, expected 0110 0 0",
                     {sum_req, acc_ready, fifo_empty, fifo_full}, fifo_count, sum_out);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        acc_valid = 1'b1;
        sfp_in    = vec8(1, 1, 1, 1, 1, 1, 1, 1);
        n_checks++;
        if (acc_ready !== 1'b1) begin
            n_errors++; $display("FAIL single_ready: got %b expected 1", acc_ready);
        end
        tick();
        acc_valid = 1'b0;
        tick();
        n_checks++;
        if (sum_req !== 1'b0 || fifo_count !== 4'd1) begin
            n_errors++; $display("FAIL single_t1: req=%b count=%0d expected req=0 count=1", sum_req, fifo_count);
        end
        tick();
        n_checks++;
        if (sum_req !== 1'b1 || sum_out !== 24'd8) begin
            n_errors++; $display("FAIL single_t2: req=%b sum_out=%0d expected req=1 sum_out=8", sum_req, sum_out);
        end
        sum_ack = 1'b1;
        tick();
        n_checks++;
        if (sum_req !== 1'b0 || fifo_empty !== 1'b1) begin
            n_errors++; $display("FAIL single_ack: req=%b empty=%b expected 0 1", sum_req, fifo_empty);
        end
        sum_ack = 1'b0;
        tick();
    endtask

    task automatic test_values();
        logic [SW-1:0] v;
        bit ok;
        send(vec8(-1, -2, 3, -4, 5, -6, 7, -8));
        do_handshake(v, ok);
        n_checks++;
        if (!ok || v !== 24'd36) begin
            n_errors++; $display("FAIL mixed_signs: got %0d (ok=%b) expected 36", v, ok);
        end
        send(vec8(524288, 524288, 524288, 524288, 524288, 524288, 524288, 524288));
        do_handshake(v, ok);
        n_checks++;
        if (!ok || v !== 24'h400000) begin
            n_errors++; $display("FAIL most_negative: got %0h (ok=%b) expected 400000", v, ok);
        end
    endtask

    task automatic test_backpressure();
        logic [SW-1:0] v;
        bit ok;
        int idx = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            acc_valid = 1'b1;
            sfp_in    = vec1(idx + 1);
            n_checks++;
            if (acc_ready !== (cyc < 8)) begin
                n_errors++; $display("FAIL bp_ready[%0d]: got %b expected %b", cyc, acc_ready, (cyc < 8));
            end
            if (acc_ready) idx++;
            tick();
        end
        acc_valid = 1'b0;
        n_checks++;
        if (idx != 8 || fifo_count !== 4'd8 || fifo_full !== 1'b1) begin
            n_errors++; $display("FAIL bp_full: accepted=%0d count=%0d full=%b expected 8 8 1", idx, fifo_count, fifo_full);
        end
        for (int i = 1; i <= 8; i++) begin
            do_handshake(v, ok);
            n_checks++;
            if (!ok || v !== SW'(i)) begin
                n_errors++; $display("FAIL bp_order[%0d]: got %0d (ok=%b) expected %0d", i, v, ok, i);
            end
            if (i == 1) begin
                n_checks++;
                if (acc_ready !== 1'b1 || fifo_count !== 4'd7) begin
                    n_errors++; $display("FAIL bp_reready: rdy=%b count=%0d expected 1 7", acc_ready, fifo_count);
                end
            end
        end
        n_checks++;
        if (fifo_empty !== 1'b1) begin
            n_errors++; $display("FAIL bp_drained: empty=%b expected 1", fifo_empty);
        end
    endtask

    task automatic test_push_pop_same();
        logic [SW-1:0] v;
        bit ok;
        send(vec1(11));
        send(vec1(12));
        send(vec1(13));
        tick();
        n_checks++;
        if (fifo_count !== 4'd3 || sum_req !== 1'b1 || sum_out !== 24'd11) begin
            n_errors++; $display("FAIL pp_setup: count=%0d req=%b sum_out=%0d expected 3 1 11", fifo_count, sum_req, sum_out);
        end
        send(vec1(14));
        sum_ack = 1'b1;
        tick();
        n_checks++;
        if (fifo_count !== 4'd3 || sum_req !== 1'b0) begin
            n_errors++; $display("FAIL pp_same_edge: count=%0d req=%b expected 3 0", fifo_count, sum_req);
        end
        sum_ack = 1'b0;
        tick();
        for (int i = 12; i <= 14; i++) begin
            do_handshake(v, ok);
            n_checks++;
            if (!ok || v !== SW'(i)) begin
                n_errors++; $display("FAIL pp_order: got %0d (ok=%b) expected %0d", v, ok, i);
            end
        end
    endtask

    task automatic test_wrap();
        logic [SW-1:0] v;
        bit ok;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) begin
                acc_valid = 1'b1;
                sfp_in    = vec8(-(100*r + i + 1), 0, 0, 0, 0, 0, 0, 0);
                tick();
            end
            acc_valid = 1'b0;
            tick();
            n_checks++;
            if (fifo_full !== 1'b1) begin
                n_errors++; $display("FAIL wrap_full[%0d]: full=%b expected 1", r, fifo_full);
            end
            for (int i = 0; i < 8; i++) begin
                do_handshake(v, ok);
                n_checks++;
                if (!ok || v !== SW'(100*r + i + 1)) begin
                    n_errors++; $display("FAIL wrap_order[%0d.%0d]: got %0d (ok=%b) expected %0d", r, i, v, ok, 100*r + i + 1);
                end
            end
        end
    endtask

    task automatic test_early_ack();
        sum_ack = 1'b1;
        tick();
        send(vec1(7));
        tick(); tick(); tick();
        n_checks++;
        if (sum_req !== 1'b0 || fifo_count !== 4'd1) begin
            n_errors++; $display("FAIL early_ack_block: req=%b count=%0d expected 0 1", sum_req, fifo_count);
        end
        sum_ack = 1'b0;
        tick();
        n_checks++;
        if (sum_req !== 1'b1 || sum_out !== 24'd7) begin
            n_errors++; $display("FAIL early_ack_launch: req=%b sum_out=%0d expected 1 7", sum_req, sum_out);
        end
        sum_ack = 1'b1;
        tick();
        sum_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [SW-1:0] v;
        bit ok;
        send(vec1(1));
        send(vec1(2));
        send(vec1(3));
        send(vec1(4));
        tick(); tick();
        n_checks++;
        if (sum_req !== 1'b1 || fifo_count !== 4'd4) begin
            n_errors++; $display("FAIL rst_setup: req=%b count=%0d expected 1 4", sum_req, fifo_count);
        end
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (sum_req !== 1'b0 || sum_out !== '0 || fifo_count !== 4'd0 || fifo_empty !== 1'b1 || acc_ready !== 1'b1) begin
            n_errors++; $display("FAIL rst_async: req=%b sum_out=%0d count=%0d empty=%b rdy=%b expected 0 0 0 1 1",
                                 sum_req, sum_out, fifo_count, fifo_empty, acc_ready);
        end
        tick();
        reset = 1'b1;
        tick();
        send(vec8(5, 0, 0, 0, 0, 0, 0, 0));
        do_handshake(v, ok);
        n_checks++;
        if (!ok || v !== 24'd5 || fifo_empty !== 1'b1) begin
            n_errors++; $display("FAIL rst_recover: got %0d (ok=%b) empty=%b expected 5 1", v, ok, fifo_empty);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_values();
        test_backpressure();
        test_push_pop_same();
        test_wrap();
        test_early_ack();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
